// File: rtl/matrix_pkg.sv
// Shared definitions for the key-matrix scanner: geometry, FSM states and
// the one-hot column decode that inverts the column demultiplexer mapping.
package matrix_pkg;

    localparam int NUM_COLS = 5;
    localparam int NUM_ROWS = 4;

    typedef enum logic [1:0] {
        ST_SCAN     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_REPORT   = 2'd2,
        ST_RELEASE  = 2'd3
    } scan_state_t;

    function automatic logic is_onehot5(input logic [4:0] v);
        return (v != 5'd0) && ((v & (v - 5'd1)) == 5'd0);
    endfunction

    // Line c_k maps back to index k; anything that is not one-hot decodes to 0.
    function automatic logic [2:0] onehot5_to_idx(input logic [4:0] v);
        logic [2:0] idx;
        case (v)
            5'b00001: idx = 3'd0;
            5'b00010: idx = 3'd1;
            5'b00100: idx = 3'd2;
            5'b01000: idx = 3'd3;
            5'b10000: idx = 3'd4;
            default:  idx = 3'd0;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/matrix_key_scanner_sync2.sv
// Two-flop synchronizer for asynchronous level inputs, parameterized width.
module sync2 #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_r;
    logic [WIDTH-1:0] sync_r;

    // Metastability filter chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_r <= {WIDTH{1'b0}};
            sync_r <= {WIDTH{1'b0}};
        end else begin
            meta_r <= d;
            sync_r <= meta_r;
        end
    end

    assign q = sync_r;

endmodule

// File: rtl/matrix_key_scanner.sv
// Row-strobing 4x5 key matrix scanner: debounces one key at a time and
// hands its row/column code out over a valid/ready handshake.
module matrix_key_scanner
    import matrix_pkg::*;
#(
    parameter int SCAN_DIV     = 16,
    parameter int DEBOUNCE_CYC = 1000
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [NUM_COLS-1:0] col_in,
    output logic [NUM_ROWS-1:0] row_out,
    output logic                key_valid,
    input  logic                key_ready,
    output logic [1:0]          key_row,
    output logic [2:0]          key_col
);

    localparam int DW = $clog2(SCAN_DIV);
    localparam int CW = $clog2(DEBOUNCE_CYC + 1);

    logic [4:0]   col_s;
    scan_state_t  state_r,     state_nx;
    logic [DW-1:0] dwell_r,    dwell_nx;
    logic [CW-1:0] deb_r,      deb_nx;
    logic [1:0]   row_idx_r,   row_idx_nx;
    logic [3:0]   row_out_r;
    logic [4:0]   lat_cols_r,  lat_cols_nx;
    logic [1:0]   lat_row_r,   lat_row_nx;
    logic         key_valid_r, key_valid_nx;
    logic [1:0]   key_row_r,   key_row_nx;
    logic [2:0]   key_col_r,   key_col_nx;
    logic         advance_s;

    sync2 #(.WIDTH(NUM_COLS)) u_col_sync (
        .clk   (clk),
        .rst_n (reset_n),
        .d     (col_in),
        .q     (col_s)
    );

    // Next-state, counter and output-register logic.
    always_comb begin
        state_nx     = state_r;
        dwell_nx     = dwell_r;
        deb_nx       = deb_r;
        lat_cols_nx  = lat_cols_r;
        lat_row_nx   = lat_row_r;
        key_valid_nx = key_valid_r;
        key_row_nx   = key_row_r;
        key_col_nx   = key_col_r;
        advance_s    = 1'b0;

        case (state_r)
            ST_SCAN: begin
                if (dwell_r == DW'(SCAN_DIV - 1)) begin
                    dwell_nx = {DW{1'b0}};
                    if (is_onehot5(col_s)) begin
                        lat_cols_nx = col_s;
                        lat_row_nx  = row_idx_r;
                        deb_nx      = {CW{1'b0}};
                        state_nx    = ST_DEBOUNCE;
                    end else begin
                        advance_s = 1'b1;
                    end
                end else begin
                    dwell_nx = dwell_r + DW'(1);
                end
            end
            ST_DEBOUNCE: begin
                if (col_s != lat_cols_r) begin
                    deb_nx    = {CW{1'b0}};
                    state_nx  = ST_SCAN;
                    advance_s = 1'b1;
                end else if (deb_r == CW'(DEBOUNCE_CYC - 1)) begin
                    deb_nx       = {CW{1'b0}};
                    state_nx     = ST_REPORT;
                    key_valid_nx = 1'b1;
                    key_row_nx   = lat_row_r;
                    key_col_nx   = onehot5_to_idx(lat_cols_r);
                end else begin
                    deb_nx = deb_r + CW'(1);
                end
            end
            ST_REPORT: begin
                if (key_ready) begin
                    key_valid_nx = 1'b0;
                    deb_nx       = {CW{1'b0}};
                    state_nx     = ST_RELEASE;
                end else begin
                    key_valid_nx = 1'b1;
                end
            end
            ST_RELEASE: begin
                // Any contact at all restarts the release qualification.
                if (col_s != 5'd0) begin
                    deb_nx = {CW{1'b0}};
                end else if (deb_r == CW'(DEBOUNCE_CYC - 1)) begin
                    deb_nx    = {CW{1'b0}};
                    dwell_nx  = {DW{1'b0}};
                    state_nx  = ST_SCAN;
                    advance_s = 1'b1;
                end else begin
                    deb_nx = deb_r + CW'(1);
                end
            end
            default: begin
                state_nx     = ST_SCAN;
                dwell_nx     = {DW{1'b0}};
                deb_nx       = {CW{1'b0}};
                key_valid_nx = 1'b0;
            end
        endcase

        if (advance_s) begin
            row_idx_nx = row_idx_r + 2'd1;
        end else begin
            row_idx_nx = row_idx_r;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= ST_SCAN;
            dwell_r     <= {DW{1'b0}};
            deb_r       <= {CW{1'b0}};
            row_idx_r   <= 2'd0;
            row_out_r   <= 4'b0001;
            lat_cols_r  <= 5'd0;
            lat_row_r   <= 2'd0;
            key_valid_r <= 1'b0;
            key_row_r   <= 2'd0;
            key_col_r   <= 3'd0;
        end else begin
            state_r     <= state_nx;
            dwell_r     <= dwell_nx;
            deb_r       <= deb_nx;
            row_idx_r   <= row_idx_nx;
            row_out_r   <= 4'b0001 << row_idx_nx;
            lat_cols_r  <= lat_cols_nx;
            lat_row_r   <= lat_row_nx;
            key_valid_r <= key_valid_nx;
            key_row_r   <= key_row_nx;
            key_col_r   <= key_col_nx;
        end
    end

    assign row_out   = row_out_r;
    assign key_valid = key_valid_r;
    assign key_row   = key_row_r;
    assign key_col   = key_col_r;

endmodule
